jts16_vtimer: RTL



---
 rtl/jts16_vtimer_if.sv | 25 ++
 rtl/jts16_vtimer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/jts16_vtimer_if.sv
// rtl/jts16_vtimer_if.sv - pixel-enable/adjust inputs and video timing outputs of jts16_vtimer
interface jts16_vtimer_if;
    logic       pxl_cen;
    logic [3:0] h_adj;
    logic [3:0] v_adj;
    logic [8:0] hdump;
    logic [8:0] vdump;
    logic       LHBL;
    logic       LVBL;
    logic       HS;
    logic       VS;
    logic       hstart;
    logic       vint;
    logic       frame;

    modport master (
        input  pxl_cen, h_adj, v_adj,
        output hdump, vdump, LHBL, LVBL, HS, VS, hstart, vint, frame
    );

    modport slave (
        output pxl_cen, h_adj, v_adj,
        input  hdump, vdump, LHBL, LVBL, HS, VS, hstart, vint, frame
    );
endinterface

// File: rtl/jts16_vtimer.sv
// rtl/jts16_vtimer.sv - pixel/line counters with blanking, sync, vint and frame flags; VTIMER_ADJ_EN adds h_adj/v_adj sync offsets
module jts16_vtimer #(
    parameter int HTOTAL   = 400,
    parameter int HB_START = 320,
    parameter int HB_END   = 0,
    parameter int HS_START = 336,
    parameter int HS_END   = 368,
    parameter int VTOTAL   = 262,
    parameter int VB_START = 224,
    parameter int VB_END   = 0,
    parameter int VS_START = 240,
    parameter int VS_END   = 243
) (
    input  logic           clk,
    input  logic           rst_n,
    jts16_vtimer_if.master vt
);
    localparam logic [8:0] H_LAST     = 9'(HTOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(VTOTAL - 1);
    localparam logic [8:0] HB_START_C = 9'(HB_START);
    localparam logic [8:0] HB_END_C   = 9'(HB_END);
    localparam logic [8:0] HS_START_C = 9'(HS_START);
    localparam logic [8:0] HS_END_C   = 9'(HS_END);
    localparam logic [8:0] VB_START_C = 9'(VB_START);
    localparam logic [8:0] VB_END_C   = 9'(VB_END);
    localparam logic [8:0] VS_START_C = 9'(VS_START);
    localparam logic [8:0] VS_END_C   = 9'(VS_END);

    logic [8:0] hdump_q, hdump_d;
    logic [8:0] vdump_q, vdump_d;
    logic       lhbl_q, lhbl_d;
    logic       lvbl_q, lvbl_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       hstart_q, hstart_d;
    logic       vint_q, vint_d;
    logic       frame_q, frame_d;
    logic       h_wrap, v_wrap;
    logic [8:0] h_next, v_next;
    logic [8:0] hs_set, hs_clr, vs_set, vs_clr;

`ifdef VTIMER_ADJ_EN
    localparam logic [9:0] H_TOT = 10'(HTOTAL);
    localparam logic [9:0] V_TOT = 10'(VTOTAL);

    logic [3:0] h_adj_q, h_adj_d;
    logic [3:0] v_adj_q, v_adj_d;

    // base + signed 4-bit offset folded back into 0..total-1
    function automatic logic [8:0] wrap_add(input logic [8:0] base, input logic [3:0] adj,
                                            input logic [9:0] total);
        logic [10:0] sum;
        sum = {2'b00, base} + {{7{adj[3]}}, adj};
        if (sum[10])
            sum = sum + {1'b0, total};
        else if (sum >= {1'b0, total})
            sum = sum - {1'b0, total};
        return sum[8:0];
    endfunction

    // offsets only change at the frame boundary so sync edges never move mid-frame
    always_comb begin
        h_adj_d = h_adj_q;
        v_adj_d = v_adj_q;
        if (vt.pxl_cen && h_wrap && v_wrap) begin
            h_adj_d = vt.h_adj;
            v_adj_d = vt.v_adj;
        end
        hs_set = wrap_add(HS_START_C, h_adj_q, H_TOT);
        hs_clr = wrap_add(HS_END_C,   h_adj_q, H_TOT);
        vs_set = wrap_add(VS_START_C, v_adj_q, V_TOT);
        vs_clr = wrap_add(VS_END_C,   v_adj_q, V_TOT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_adj_q <= vt.h_adj;
            v_adj_q <= vt.v_adj;
        end else begin
            h_adj_q <= h_adj_d;
            v_adj_q <= v_adj_d;
        end
    end
`else
    logic unused_adj;
    assign unused_adj = ^{vt.h_adj, vt.v_adj};
    assign hs_set     = HS_START_C;
    assign hs_clr     = HS_END_C;
    assign vs_set     = VS_START_C;
    assign vs_clr     = VS_END_C;
`endif

    // flags compare against the next counter value so they move in the same clk as the counters
    always_comb begin
        hdump_d  = hdump_q;
        vdump_d  = vdump_q;
        lhbl_d   = lhbl_q;
        lvbl_d   = lvbl_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        frame_d  = frame_q;
        hstart_d = 1'b0;
        vint_d   = 1'b0;
        h_wrap   = (hdump_q == H_LAST);
        v_wrap   = (vdump_q == V_LAST);
        h_next   = h_wrap ? 9'd0 : 9'(hdump_q + 9'd1);
        v_next   = v_wrap ? 9'd0 : 9'(vdump_q + 9'd1);

        if (vt.pxl_cen) begin
            hdump_d = h_next;
            if (h_next == HB_START_C)    lhbl_d = 1'b0;
            else if (h_next == HB_END_C) lhbl_d = 1'b1;
            if (h_next == hs_set)        hs_d = 1'b1;
            else if (h_next == hs_clr)   hs_d = 1'b0;

            if (h_wrap) begin
                hstart_d = 1'b1;
                vdump_d  = v_next;
                vint_d   = (v_next == VB_START_C);
                if (v_next == VB_START_C)    lvbl_d = 1'b0;
                else if (v_next == VB_END_C) lvbl_d = 1'b1;
                if (v_next == vs_set)        vs_d = 1'b1;
                else if (v_next == vs_clr)   vs_d = 1'b0;
                if (v_wrap) frame_d = ~frame_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdump_q  <= 9'd0;
            vdump_q  <= 9'd0;
            lhbl_q   <= 1'b1;
            lvbl_q   <= 1'b1;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hstart_q <= 1'b0;
            vint_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hdump_q  <= hdump_d;
            vdump_q  <= vdump_d;
            lhbl_q   <= lhbl_d;
            lvbl_q   <= lvbl_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hstart_q <= hstart_d;
            vint_q   <= vint_d;
            frame_q  <= frame_d;
        end
    end

    assign vt.hdump  = hdump_q;
    assign vt.vdump  = vdump_q;
    assign vt.LHBL   = lhbl_q;
    assign vt.LVBL   = lvbl_q;
    assign vt.HS     = hs_q;
    assign vt.VS     = vs_q;
    assign vt.hstart = hstart_q;
    assign vt.vint   = vint_q;
    assign vt.frame  = frame_q;
endmodule
